// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single external memory port between instruction fetch (IF) and
//   load/store (LS). Runs one memory transaction at a time, returns read data
//   with a one-cycle done pulse to the winner, and aborts with bus_err if the
//   memory does not acknowledge within TIMEOUT cycles.
//
//   Ports
//     clk, rst                       clock, synchronous active-high reset
//     if_req/if_addr                 fetch request (held until if_done)
//     if_rdata/if_done               fetch result, done pulse
//     ls_req/ls_we/ls_addr/ls_wdata  load/store request (held until ls_done)
//     ls_rdata/ls_done               load result, done pulse
//     mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//     mem_rdata/mem_ack              memory response
//     hold_n                         0 = freeze pipeline (combinational)
//     bus_err                        pulses with done on timeout abort
//
//   state  | meaning
//   IDLE   | no access in flight, arbitrating
//   IF_ACC | fetch access on the memory port, waiting for mem_ack
//   LS_ACC | load/store access on the memory port, waiting for mem_ack

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 16,
    parameter int DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          hold_n,
    output logic          bus_err
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam int BC_W = $clog2(DATA_BURST + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(DATA_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [BC_W-1:0] burst_cnt;

    logic ls_win;
    logic if_win;
    logic grant_ls;
    logic grant_if;

    // The winner is picked from the raw requests; a winner that is still in
    // its own done cycle is the request that just finished, so nobody is
    // granted that cycle. This keeps a finishing LS from handing its slot to
    // IF before the burst limit has been reached.
    assign ls_win   = ls_req && (!if_req || (burst_cnt < BURST_MAX));
    assign if_win   = !ls_win && if_req;
    assign grant_ls = ls_win && !ls_done;
    assign grant_if = if_win && !if_done;

    assign hold_n = !((ls_req && !ls_done) || (if_req && !if_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            burst_cnt <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ls_we;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        to_cnt    <= '0;
                        state     <= LS_ACC;
                        if (!if_req)
                            burst_cnt <= '0;
                        else if (burst_cnt != BURST_MAX)
                            burst_cnt <= burst_cnt + 1'b1;
                    end else if (grant_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        to_cnt    <= '0;
                        burst_cnt <= '0;
                        state     <= IF_ACC;
                    end
                end
                IF_ACC, LS_ACC: begin
                    if (mem_ack || (to_cnt == TO_LAST)) begin
                        // Timeout abort returns zero data with bus_err.
                        if (state == IF_ACC) begin
                            if_rdata <= mem_ack ? mem_rdata : '0;
                            if_done  <= 1'b1;
                        end else begin
                            ls_rdata <= mem_ack ? mem_rdata : '0;
                            ls_done  <= 1'b1;
                        end
                        bus_err <= !mem_ack;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: single fetch, simultaneous requests,
//   LS burst limiting, timeout abort, reset mid-access and stray acks.

module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int TIMEOUT    = 16;
    localparam int DATA_BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] ls_rdata;
    logic          ls_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          hold_n;
    logic          bus_err;

    logic          force_ack   = 1'b0;
    logic [DW-1:0] force_rdata = '0;
    logic          auto_ack    = 1'b0;

    logic          prev_req = 1'b0;
    logic          log_we[$];
    logic [AW-1:0] log_addr[$];

    int n_cmp = 0;
    int n_mis = 0;
    int base;
    int got_if;
    int got_ls;
    logic [AW-1:0] exp_addr [6];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .DATA_BURST(DATA_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hold_n(hold_n), .bus_err(bus_err)
    );

    // Memory responder: in auto mode acks every active cycle with ~addr.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = force_ack || (auto_ack && mem_req);
            mem_rdata = auto_ack ? ~mem_addr : force_rdata;
        end
    end

    // Grant log: one entry per rising edge of mem_req.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
            end
            prev_req = mem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        tick(); tick();
        chk_val("rst_mem_req",  32'(mem_req),  32'd0);
        chk_val("rst_mem_addr", mem_addr,      32'd0);
        chk_val("rst_dones",    32'({if_done, ls_done, bus_err}), 32'd0);
        chk_val("rst_rdata",    if_rdata | ls_rdata, 32'd0);
        chk_val("rst_hold_n",   32'(hold_n),   32'd1);
        rst = 1'b0;
        tick();

        // 1: single fetch, ack in cycle 1
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk_val("t1_hold_n_req", 32'(hold_n), 32'd0);
        tick();
        chk_val("t1_mem_req",  32'(mem_req), 32'd1);
        chk_val("t1_mem_addr", mem_addr,     32'h100);
        chk_val("t1_mem_we",   32'(mem_we),  32'd0);
        chk_val("t1_no_done",  32'(if_done), 32'd0);
        force_ack = 1'b1; force_rdata = 32'hDEADBEEF;
        tick();
        chk_val("t1_if_done",  32'(if_done), 32'd1);
        chk_val("t1_if_rdata", if_rdata,     32'hDEADBEEF);
        chk_val("t1_hold_n",   32'(hold_n),  32'd1);
        chk_val("t1_mem_req0", 32'(mem_req), 32'd0);
        if_req = 1'b0; force_ack = 1'b0;
        tick();
        chk_val("t1_pulse", 32'(if_done), 32'd0);

        // 2: simultaneous IF and LS store; LS first
        base = log_we.size();
        auto_ack = 1'b1;
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h55;
        tick();
        chk_val("t2_ls_we",    32'(mem_we), 32'd1);
        chk_val("t2_ls_addr",  mem_addr,    32'h200);
        chk_val("t2_ls_wdata", mem_wdata,   32'h55);
        got_if = 0;
        for (int i = 0; i < 20 && got_if == 0; i++) begin
            tick();
            chk_val("t2_one_done", 32'(if_done && ls_done), 32'd0);
            if (ls_done) begin ls_req = 1'b0; ls_we = 1'b0; end
            if (if_done) begin
                if_req = 1'b0; got_if = 1;
                chk_val("t2_if_rdata", if_rdata, ~32'h300);
            end
        end
        chk_val("t2_if_done_seen", 32'(got_if), 32'd1);
        chk_val("t2_grants", 32'(log_we.size() - base), 32'd2);
        if (log_we.size() - base == 2) begin
            chk_val("t2_g0_we",   32'(log_we[base]),   32'd1);
            chk_val("t2_g0_addr", log_addr[base],      32'h200);
            chk_val("t2_g1_we",   32'(log_we[base+1]), 32'd0);
            chk_val("t2_g1_addr", log_addr[base+1],    32'h300);
        end
        tick();

        // 3: LS back-to-back with IF pending: 4 LS, 1 IF, then LS
        base = log_we.size();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
        if_req = 1'b1; if_addr = 32'h500;
        got_ls = 0;
        for (int i = 0; i < 100 && got_ls == 0; i++) begin
            tick();
            if (if_done) if_req = 1'b0;
            if (ls_done && (log_we.size() - base >= 6)) begin
                ls_req = 1'b0; got_ls = 1;
            end
        end
        chk_val("t3_finished", 32'(got_ls), 32'd1);
        chk_val("t3_grants", 32'(log_we.size() - base), 32'd6);
        exp_addr[0] = 32'h400; exp_addr[1] = 32'h400; exp_addr[2] = 32'h400;
        exp_addr[3] = 32'h400; exp_addr[4] = 32'h500; exp_addr[5] = 32'h400;
        if (log_we.size() - base >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk_val($sformatf("t3_g%0d_addr", k), log_addr[base+k], exp_addr[k]);
                chk_val($sformatf("t3_g%0d_we", k), 32'(log_we[base+k]), 32'd0);
            end
        end
        chk_val("t3_ls_rdata", ls_rdata, ~32'h400);
        tick();

        // 4: timeout without ack
        auto_ack = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
        tick();
        chk_val("t4_mem_req", 32'(mem_req), 32'd1);
        repeat (15) tick();
        chk_val("t4_no_done_yet", 32'(ls_done), 32'd0);
        chk_val("t4_still_req",   32'(mem_req), 32'd1);
        tick();
        chk_val("t4_ls_done",  32'(ls_done),  32'd1);
        chk_val("t4_bus_err",  32'(bus_err),  32'd1);
        chk_val("t4_ls_rdata", ls_rdata,      32'd0);
        chk_val("t4_mem_req0", 32'(mem_req),  32'd0);
        ls_req = 1'b0;
        tick();
        chk_val("t4_err_pulse", 32'({bus_err, ls_done}), 32'd0);

        // 5: reset during LS_ACC, late ack after release
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h700; ls_wdata = 32'hAB;
        tick();
        tick();
        chk_val("t5_in_acc", 32'(mem_req), 32'd1);
        rst = 1'b1; ls_req = 1'b0; ls_we = 1'b0;
        tick();
        chk_val("t5_rst_mem",   32'({mem_req, mem_we}), 32'd0);
        chk_val("t5_rst_addr",  mem_addr,  32'd0);
        chk_val("t5_rst_wdata", mem_wdata, 32'd0);
        chk_val("t5_rst_done",  32'({if_done, ls_done, bus_err}), 32'd0);
        rst = 1'b0;
        tick();
        force_ack = 1'b1; force_rdata = 32'h1234;
        tick();
        chk_val("t5_late_done", 32'(ls_done), 32'd0);
        chk_val("t5_late_req",  32'(mem_req), 32'd0);
        force_ack = 1'b0;
        tick();
        chk_val("t5_late_done2", 32'(ls_done), 32'd0);
        chk_val("t5_ls_rdata",   ls_rdata,     32'd0);

        // 6: stray ack while idle
        force_ack = 1'b1; force_rdata = 32'h99;
        #1;
        chk_val("t6_hold_n0", 32'(hold_n), 32'd1);
        tick(); tick();
        chk_val("t6_dones",  32'({if_done, ls_done, bus_err}), 32'd0);
        chk_val("t6_mem_req", 32'(mem_req), 32'd0);
        chk_val("t6_hold_n",  32'(hold_n),  32'd1);
        chk_val("t6_rdata",   if_rdata | ls_rdata, 32'd0);
        force_ack = 1'b0;
        tick();
        auto_ack = 1'b1;
        if_req = 1'b1; if_addr = 32'h800;
        got_if = 0;
        for (int i = 0; i < 10 && got_if == 0; i++) begin
            tick();
            if (if_done) begin
                if_req = 1'b0; got_if = 1;
                chk_val("t6_after_rdata", if_rdata, ~32'h800);
            end
        end
        chk_val("t6_after_done", 32'(got_if), 32'd1);
        auto_ack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
